io_bus_hub: RTL and testbench

//   Parametrised CPU-to-peripheral I/O interconnect for NCH memory-mapped peripheral

---
 rtl/io_bus_hub_pkg.sv | 12 +
 rtl/io_tick_gen.sv | 34 +++
 rtl/io_bus_hub.sv | 170 +++++++++++++++++
 tb/tb_io_bus_hub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/io_bus_hub_pkg.sv
// Shared constants for the CPU-to-peripheral I/O hub: FSM encoding and default data width.
package io_bus_hub_pkg;

   localparam int unsigned LEN = 8;

   typedef enum logic [1:0] {
      IOHUB_IDLE   = 2'd0,
      IOHUB_ACCESS = 2'd1,
      IOHUB_RESP   = 2'd2
   } iohub_state_e;

endpackage

// File: rtl/io_tick_gen.sv
// Free-running divider producing a registered 1-cycle enable strobe every TICK_DIV cycles.
module io_tick_gen #(
   parameter int unsigned TICK_DIV = 16
) (
   input  logic clk_sys,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      // Strobe is registered alongside the count it reflects.
      tick_d = (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/io_bus_hub.sv
// CPU-to-peripheral interconnect: channel decode, req/ack handshake with timeout and
// unmapped-address error, plus a free-running tick enable.
module io_bus_hub
   import io_bus_hub_pkg::*;
#(
   parameter int unsigned NCH      = 3,
   parameter int unsigned DW       = LEN,
   parameter int unsigned AW       = 8,
   parameter int unsigned CH_BITS  = 2,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TICK_DIV = 16
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   output logic                  tick_o,
   input  logic                  m_req,
   input  logic                  m_we,
   input  logic [AW-1:0]         m_addr,
   input  logic [DW-1:0]         m_wdata,
   output logic [DW-1:0]         m_rdata,
   output logic                  m_ack,
   output logic                  m_err,
   output logic                  m_busy,
   output logic [NCH-1:0]        p_sel,
   output logic                  p_we,
   output logic [AW-CH_BITS-1:0] p_addr,
   output logic [DW-1:0]         p_wdata,
   input  logic [NCH*DW-1:0]     p_rdata,
   input  logic [NCH-1:0]        p_ack
);

   localparam int unsigned PAW = AW - CH_BITS;
   localparam int unsigned TW  = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]      TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CH_BITS:0]   NCH_LIM = (CH_BITS + 1)'(NCH);

   iohub_state_e state_q, state_d;

   logic [NCH-1:0] p_sel_q, p_sel_d;
   logic           p_we_q, p_we_d;
   logic [PAW-1:0] p_addr_q, p_addr_d;
   logic [DW-1:0]  p_wdata_q, p_wdata_d;
   logic [DW-1:0]  m_rdata_q, m_rdata_d;
   logic           m_ack_q, m_ack_d;
   logic           m_err_q, m_err_d;
   logic [TW-1:0]  tcnt_q, tcnt_d;

   logic [CH_BITS-1:0] ch;
   logic               ch_mapped;
   logic [NCH-1:0]     ch_onehot;
   logic               ack_hit;
   logic [DW-1:0]      sel_rdata;

   io_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_sys (clk_sys),
      .rst     (rst),
      .tick_o  (tick_o)
   );

   always_comb begin
      ch        = m_addr[AW-1 -: CH_BITS];
      ch_mapped = ({1'b0, ch} < NCH_LIM);
      for (int k = 0; k < NCH; k++) begin
         ch_onehot[k] = (ch == CH_BITS'(k));
      end
   end

   // Only the selected channel's ack and read data are honoured.
   always_comb begin
      ack_hit   = |(p_ack & p_sel_q);
      sel_rdata = '0;
      for (int k = 0; k < NCH; k++) begin
         sel_rdata = sel_rdata | (p_rdata[k*DW +: DW] & {DW{p_sel_q[k]}});
      end
   end

   always_comb begin
      state_d   = state_q;
      p_sel_d   = p_sel_q;
      p_we_d    = p_we_q;
      p_addr_d  = p_addr_q;
      p_wdata_d = p_wdata_q;
      m_rdata_d = m_rdata_q;
      m_ack_d   = 1'b0;
      m_err_d   = 1'b0;
      tcnt_d    = tcnt_q;

      unique case (state_q)
         IOHUB_IDLE: begin
            if (m_req) begin
               p_we_d    = m_we;
               p_addr_d  = m_addr[PAW-1:0];
               p_wdata_d = m_wdata;
               tcnt_d    = '0;
               if (ch_mapped) begin
                  p_sel_d = ch_onehot;
                  state_d = IOHUB_ACCESS;
               end else begin
                  m_ack_d   = 1'b1;
                  m_err_d   = 1'b1;
                  m_rdata_d = '0;
                  state_d   = IOHUB_RESP;
               end
            end
         end
         IOHUB_ACCESS: begin
            tcnt_d = tcnt_q + TW'(1);
            if (ack_hit) begin
               m_ack_d = 1'b1;
               p_sel_d = '0;
               state_d = IOHUB_RESP;
               if (!p_we_q) begin
                  m_rdata_d = sel_rdata;
               end
            end else if (tcnt_q == TO_LAST) begin
               m_ack_d   = 1'b1;
               m_err_d   = 1'b1;
               m_rdata_d = '0;
               p_sel_d   = '0;
               state_d   = IOHUB_RESP;
            end
         end
         IOHUB_RESP: begin
            tcnt_d  = '0;
            state_d = IOHUB_IDLE;
         end
         default: begin
            p_sel_d = '0;
            tcnt_d  = '0;
            state_d = IOHUB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!rst) begin
         state_q   <= IOHUB_IDLE;
         p_sel_q   <= '0;
         p_we_q    <= 1'b0;
         p_addr_q  <= '0;
         p_wdata_q <= '0;
         m_rdata_q <= '0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         p_sel_q   <= p_sel_d;
         p_we_q    <= p_we_d;
         p_addr_q  <= p_addr_d;
         p_wdata_q <= p_wdata_d;
         m_rdata_q <= m_rdata_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign m_busy  = (state_q != IOHUB_IDLE);
   assign p_sel   = p_sel_q;
   assign p_we    = p_we_q;
   assign p_addr  = p_addr_q;
   assign p_wdata = p_wdata_q;
   assign m_rdata = m_rdata_q;
   assign m_ack   = m_ack_q;
   assign m_err   = m_err_q;

endmodule

// File: tb/tb_io_bus_hub.sv
// Randomized bench for io_bus_hub against a transaction-level latency/response model.
module tb_io_bus_hub;

   localparam int unsigned NCH = 3;
   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 8;
   localparam int unsigned CHB = 2;
   localparam int unsigned TO  = 8;
   localparam int unsigned TD  = 16;

   logic                clk_sys = 1'b0;
   logic                rst = 1'b0;
   logic                tick_o;
   logic                m_req = 1'b0;
   logic                m_we = 1'b0;
   logic [AW-1:0]       m_addr = '0;
   logic [DW-1:0]       m_wdata = '0;
   logic [DW-1:0]       m_rdata;
   logic                m_ack;
   logic                m_err;
   logic                m_busy;
   logic [NCH-1:0]      p_sel;
   logic                p_we;
   logic [AW-CHB-1:0]   p_addr;
   logic [DW-1:0]       p_wdata;
   logic [NCH*DW-1:0]   p_rdata = '0;
   logic [NCH-1:0]      p_ack = '0;

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_rdata = '0;

   int tk = 0;
   bit tick_chk_en = 1'b0;

   io_bus_hub #(
      .NCH      (NCH),
      .DW       (DW),
      .AW       (AW),
      .CH_BITS  (CHB),
      .TIMEOUT  (TO),
      .TICK_DIV (TD)
   ) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .tick_o  (tick_o),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .m_busy  (m_busy),
      .p_sel   (p_sel),
      .p_we    (p_we),
      .p_addr  (p_addr),
      .p_wdata (p_wdata),
      .p_rdata (p_rdata),
      .p_ack   (p_ack)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Cycles since reset release; the strobe lands on every TD-th one.
   always @(posedge clk_sys) begin
      if (!rst) tk <= 0;
      else      tk <= tk + 1;
   end

   always @(negedge clk_sys) begin
      if (tick_chk_en) check_val("tick", 32'(tick_o), 32'((tk % TD) == TD - 1));
   end

   // ack_cyc: ACCESS cycle (1-based) in which the selected channel acks; >TO means never.
   task automatic run_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int ack_cyc,
                             input logic [NCH-1:0] stray);
      int unsigned ch;
      bit mapped, acked, got;
      int exp_lat, seen_lat;
      logic exp_err, seen_err;
      logic [DW-1:0] seen_rdata;
      logic [NCH-1:0] seen_sel, mask;
      logic [NCH*DW-1:0] rd;

      ch      = int'(addr[AW-1 -: CHB]);
      mapped  = (ch < NCH);
      acked   = mapped && ack_cyc >= 1 && ack_cyc <= int'(TO);
      exp_lat = !mapped ? 1 : (acked ? ack_cyc + 1 : int'(TO) + 1);
      exp_err = !acked;
      mask    = mapped ? ~(NCH'(1) << ch) : '1;
      if (exp_err) exp_rdata = '0;

      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; p_ack = '0;
      @(posedge clk_sys);
      got = 1'b0; seen_lat = 0; seen_err = 1'b0; seen_rdata = '0; seen_sel = '0;
      for (int n = 1; n <= 20 && !got; n++) begin
         @(negedge clk_sys);
         m_req = 1'b0;
         rd = {$urandom, $urandom};
         p_rdata = rd;
         if (m_ack) begin
            got = 1'b1; seen_lat = n; seen_err = m_err; seen_rdata = m_rdata; seen_sel = p_sel;
            p_ack = '0;
         end else begin
            if (n == 1 && mapped) begin
               check_val("p_sel", 32'(p_sel), 32'(NCH'(1) << ch));
               check_val("p_addr", 32'(p_addr), 32'(addr[AW-CHB-1:0]));
               check_val("p_wdata", 32'(p_wdata), 32'(wdata));
               check_val("p_we", 32'(p_we), 32'(we));
               check_val("busy", 32'(m_busy), 32'd1);
            end
            p_ack = stray & mask;
            if (acked && n == ack_cyc) begin
               p_ack[ch] = 1'b1;
               if (!we) exp_rdata = rd[ch*DW +: DW];
            end
         end
      end
      check_val("ack_lat", 32'(seen_lat), 32'(exp_lat));
      if (got) begin
         check_val("err", 32'(seen_err), 32'(exp_err));
         check_val("rdata", 32'(seen_rdata), 32'(exp_rdata));
         check_val("sel_resp", 32'(seen_sel), 32'd0);
         @(negedge clk_sys);
         check_val("ack_single", 32'(m_ack), 32'd0);
         check_val("err_idle", 32'(m_err), 32'd0);
         check_val("busy_idle", 32'(m_busy), 32'd0);
      end
   endtask

   initial begin
      // Reset for 3 cycles
      rst = 1'b0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_val("rst_sel", 32'(p_sel), 32'd0);
      check_val("rst_ack", 32'(m_ack), 32'd0);
      check_val("rst_err", 32'(m_err), 32'd0);
      check_val("rst_rdata", 32'(m_rdata), 32'd0);
      check_val("rst_tick", 32'(tick_o), 32'd0);
      check_val("rst_busy", 32'(m_busy), 32'd0);
      rst = 1'b1;
      tick_chk_en = 1'b1;

      // Directed cases
      run_access(1'b1, 8'h45, 8'hA5, 3, 3'b001);
      run_access(1'b0, 8'h83, 8'h00, 1, 3'b000);
      run_access(1'b0, 8'hC0, 8'h00, 1, 3'b000);
      run_access(1'b0, 8'h12, 8'h00, 99, 3'b000);
      run_access(1'b0, 8'h12, 8'h00, 8, 3'b000);
      run_access(1'b1, 8'h7F, 8'h5A, 2, 3'b101);
      run_access(1'b0, 8'hFF, 8'h00, 2, 3'b111);

      // Randomized accesses
      for (int i = 0; i < 40; i++) begin
         run_access(1'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 10)), 3'($urandom));
      end

      // Reset during ACCESS
      m_req = 1'b1; m_we = 1'b0; m_addr = 8'h55; p_ack = '0;
      @(posedge clk_sys);
      @(negedge clk_sys);
      m_req = 1'b0;
      check_val("pre_rst_sel", 32'(p_sel), 32'b010);
      repeat (2) @(negedge clk_sys);
      rst = 1'b0;
      @(negedge clk_sys);
      exp_rdata = '0;
      check_val("mid_rst_sel", 32'(p_sel), 32'd0);
      check_val("mid_rst_ack", 32'(m_ack), 32'd0);
      check_val("mid_rst_busy", 32'(m_busy), 32'd0);
      check_val("mid_rst_rdata", 32'(m_rdata), 32'd0);
      rst = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_sys);
         check_val("post_rst_ack", 32'(m_ack), 32'd0);
      end
      run_access(1'b0, 8'h40, 8'h00, 4, 3'b000);

      repeat (2) @(negedge clk_sys);
      tick_chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
